// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline definitions for the ID-stage hazard and forwarding logic
package hazard_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stateT;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwdSelT;
  localparam int CNT_W = 16;
  // $0 is hardwired to zero, so it can never carry a dependency
  function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return rd != 5'd0 && (rd == rs || rd == rt);
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage stall/flush control for hazards that MEM/WB forwarding cannot resolve
import hazard_ctrl_pkg::*;
module hazard_ctrl (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       registerRsID,
  input  logic [4:0]       registerRtID,
  input  logic [4:0]       registerRdEX,
  input  logic             regWriteEX,
  input  logic             memReadEX,
  input  logic [4:0]       registerRdMEM,
  input  logic             memReadMEM,
  input  logic             branchID,
  input  logic             jumpID,
  input  logic             branchTakenID,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexBubble,
  output logic             ifidFlush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             busy
);
  stateT state, stateNext;
  logic [1:0] rem, remNext, need;
  logic exHit, memHit, stall;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      rem <= 2'd0;
    end else begin
      state <= stateNext;
      rem <= remNext;
    end
  // a branch resolves in ID, so a load feeding it needs two bubbles while it is still in EX
  always_comb begin
    exHit = regMatch(registerRdEX, registerRsID, registerRtID);
    memHit = regMatch(registerRdMEM, registerRsID, registerRtID);
    need = (branchID && memReadEX && exHit) ? 2'd2 :
           ((memReadEX && exHit) || (branchID && regWriteEX && !memReadEX && exHit) ||
            (branchID && memReadMEM && memHit)) ? 2'd1 : 2'd0;
    stall = state == STALL || need != 2'd0;
    remNext = state == STALL ? rem - 2'd1 : (need != 2'd0 ? need - 2'd1 : 2'd0);
    stateNext = remNext != 2'd0 ? STALL : RUN;
    pcWrite = !stall;
    ifidWrite = !stall;
    idexBubble = stall;
    ifidFlush = !stall && (jumpID || (branchID && branchTakenID));
    busy = state == STALL;
  end
  sat_counter #(.W(CNT_W)) stallCnt (.clk(clk), .reset(reset), .inc(stall), .count(stallCount));
  sat_counter #(.W(CNT_W)) flushCnt (.clk(clk), .reset(reset), .inc(ifidFlush), .count(flushCount));
endmodule
